// File: rtl/if_fetch_stage_pkg.sv
// Shared CPU definitions used by the instruction-fetch stage.
// Holds the opcode/bubble encodings, the PC step and the fetch FSM state type.
package if_fetch_stage_pkg;

    localparam logic [3:0]  HALT_OPC  = 4'hF;
    localparam logic [15:0] NOP_INSTR = 16'h0000;
    localparam logic [15:0] PC_STEP   = 16'd2;

    typedef enum logic [1:0] {
        StFetch,
        StWait,
        StHalted
    } fetch_state_e;

    function automatic logic is_halt(input logic [15:0] word);
        return word[15:12] == HALT_OPC;
    endfunction

endpackage

// File: rtl/if_pc_reg.sv
// 16-bit program counter register with synchronous reset and load enable.
module if_pc_reg #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_en,
    input  logic [15:0] pc_d,
    output logic [15:0] pc_q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else if (load_en) begin
            pc_q <= pc_d;
        end
    end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC ownership, imem request, HALT detection, redirect/stall/wait.
// All outputs are combinational from PC, state and inputs and feed the IF/ID register d-side.
module if_fetch_stage
    import if_fetch_stage_pkg::*;
#(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic [15:0] imem_addr,
    output logic        imem_req,
    input  logic [15:0] imem_data,
    input  logic        imem_ready,
    output logic [15:0] pc_out,
    output logic [15:0] pc_inc,
    output logic [15:0] instr,
    output logic        halt,
    output logic        ifid_wen
);

    fetch_state_e state_q, state_d;
    logic [15:0]  pc_q;
    logic [15:0]  pc_d;
    logic         pc_load;

    // Branch targets are halfword aligned; the low bit is dropped on purpose.
    logic         unused_redirect_lsb;
    assign unused_redirect_lsb = redirect_pc[0];

    if_pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk     (clk),
        .rst     (rst),
        .load_en (pc_load),
        .pc_d    (pc_d),
        .pc_q    (pc_q)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StFetch;
        end else begin
            state_q <= state_d;
        end
    end

    assign imem_addr = pc_q;
    assign pc_out    = pc_q;
    assign pc_inc    = pc_q + PC_STEP;

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        pc_load  = 1'b0;
        instr    = NOP_INSTR;
        halt     = 1'b0;
        ifid_wen = 1'b0;
        imem_req = 1'b0;

        if (!rst) begin
            case (state_q)
                StHalted: begin
                    halt = 1'b1;
                end
                StFetch, StWait: begin
                    imem_req = 1'b1;
                    if (redirect) begin
                        // The in-flight fetch is squashed and a bubble goes to IF/ID.
                        pc_d     = {redirect_pc[15:1], 1'b0};
                        pc_load  = 1'b1;
                        ifid_wen = 1'b1;
                        state_d  = StFetch;
                    end else if (stall) begin
                        state_d = state_q;
                    end else if (imem_ready) begin
                        instr    = imem_data;
                        ifid_wen = 1'b1;
                        if (is_halt(imem_data)) begin
                            halt    = 1'b1;
                            state_d = StHalted;
                        end else begin
                            pc_d    = pc_inc;
                            pc_load = 1'b1;
                            state_d = StFetch;
                        end
                    end else begin
                        ifid_wen = 1'b1;
                        state_d  = StWait;
                    end
                end
                default: begin
                    state_d = StFetch;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Self-checking bench for if_fetch_stage: directed literal checks plus randomized
// stimulus compared every cycle against a PC/halted-flag reference model.
module tb_if_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic [15:0] imem_addr;
    logic        imem_req;
    logic [15:0] imem_data;
    logic        imem_ready;
    logic [15:0] pc_out;
    logic [15:0] pc_inc;
    logic [15:0] instr;
    logic        halt;
    logic        ifid_wen;

    int n_checks = 0;
    int n_fails  = 0;
    logic cmp_en = 1'b0;

    // Reference model state: only the PC and whether fetch has stopped.
    logic [15:0] m_pc;
    logic        m_halted;

    always #5 clk = ~clk;

    if_fetch_stage #(
        .RESET_PC (16'h0000)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_addr   (imem_addr),
        .imem_req    (imem_req),
        .imem_data   (imem_data),
        .imem_ready  (imem_ready),
        .pc_out      (pc_out),
        .pc_inc      (pc_inc),
        .instr       (instr),
        .halt        (halt),
        .ifid_wen    (ifid_wen)
    );

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        if (rst) begin
            m_pc     <= 16'h0000;
            m_halted <= 1'b0;
        end else if (m_halted) begin
            m_pc <= m_pc;
        end else if (redirect) begin
            m_pc <= redirect_pc & 16'hFFFE;
        end else if (stall) begin
            m_pc <= m_pc;
        end else if (imem_ready) begin
            if (imem_data[15:12] == 4'hF) m_halted <= 1'b1;
            else                          m_pc     <= m_pc + 16'd2;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            logic        e_req, e_wen, e_halt, chk_instr;
            logic [15:0] e_instr;
            e_req = 1'b0; e_wen = 1'b0; e_halt = 1'b0; e_instr = 16'h0000; chk_instr = 1'b1;
            if (rst) begin
                e_req = 1'b0;
            end else if (m_halted) begin
                e_halt = 1'b1;
            end else if (redirect) begin
                e_req = 1'b1; e_wen = 1'b1;
            end else if (stall) begin
                e_req = 1'b1; chk_instr = 1'b0;
            end else if (imem_ready) begin
                e_req = 1'b1; e_wen = 1'b1; e_instr = imem_data;
                e_halt = (imem_data[15:12] == 4'hF);
            end else begin
                e_req = 1'b1; e_wen = 1'b1;
            end
            chk("cmp_pc_out", pc_out, m_pc);
            chk("cmp_imem_addr", imem_addr, m_pc);
            chk("cmp_pc_inc", pc_inc, m_pc + 16'd2);
            chk("cmp_imem_req", 16'(imem_req), 16'(e_req));
            chk("cmp_ifid_wen", 16'(ifid_wen), 16'(e_wen));
            if (chk_instr) begin
                chk("cmp_instr", instr, e_instr);
                chk("cmp_halt", 16'(halt), 16'(e_halt));
            end
        end
    end

    // Inputs change 1 time unit after the edge; literal checks sample at +3.
    task automatic apply(input logic r, input logic s, input logic rd, input logic [15:0] rp,
                         input logic rdy, input logic [15:0] d);
        rst = r; stall = s; redirect = rd; redirect_pc = rp; imem_ready = rdy; imem_data = d;
        #2;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        apply(1'b1, 1'b0, 1'b0, 16'h0, 1'b1, 16'h0);
        @(posedge clk);
        #1;
        apply(1'b1, 1'b0, 1'b0, 16'h0, 1'b1, 16'h0);
        cmp_en = 1'b1;
        chk("rst_pc", pc_out, 16'h0000);
        chk("rst_req", 16'(imem_req), 16'h0);
        chk("rst_wen", 16'(ifid_wen), 16'h0);
        chk("rst_instr", instr, 16'h0000);
        chk("rst_halt", 16'(halt), 16'h0);
        tick();

        apply(1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 16'h1234);
        chk("seq0_pc", pc_out, 16'h0000); chk("seq0_instr", instr, 16'h1234);
        chk("seq0_wen", 16'(ifid_wen), 16'h1);
        tick();
        apply(1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 16'h2345);
        chk("seq1_pc", pc_out, 16'h0002); chk("seq1_instr", instr, 16'h2345);
        tick();
        apply(1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 16'h3456);
        chk("seq2_pc", pc_out, 16'h0004); chk("seq2_inc", pc_inc, 16'h0006);
        chk("seq2_instr", instr, 16'h3456);
        tick();

        apply(1'b0, 1'b0, 1'b1, 16'h0010, 1'b1, 16'h7777);
        tick();
        apply(1'b0, 1'b0, 1'b1, 16'h0041, 1'b1, 16'h5555);
        chk("redir_pc_before", pc_out, 16'h0010); chk("redir_nop", instr, 16'h0000);
        chk("redir_wen", 16'(ifid_wen), 16'h1);
        tick();
        apply(1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 16'h1111);
        chk("redir_target", pc_out, 16'h0040);
        tick();

        apply(1'b0, 1'b0, 1'b1, 16'h0008, 1'b1, 16'h0);
        tick();
        for (int i = 0; i < 2; i++) begin
            apply(1'b0, 1'b1, 1'b0, 16'h0, 1'b1, 16'hAAAA);
            chk("stall_pc", pc_out, 16'h0008); chk("stall_wen", 16'(ifid_wen), 16'h0);
            chk("stall_req", 16'(imem_req), 16'h1);
            tick();
        end
        apply(1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 16'h2222);
        chk("stall_resume_pc", pc_out, 16'h0008); chk("stall_resume_instr", instr, 16'h2222);
        tick();
        apply(1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 16'h3333);
        chk("stall_next_pc", pc_out, 16'h000A);
        tick();

        apply(1'b0, 1'b0, 1'b1, 16'h0020, 1'b1, 16'h0);
        tick();
        for (int i = 0; i < 3; i++) begin
            apply(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 16'hF0F0);
            chk("wait_pc", pc_out, 16'h0020); chk("wait_nop", instr, 16'h0000);
            chk("wait_halt", 16'(halt), 16'h0); chk("wait_wen", 16'(ifid_wen), 16'h1);
            tick();
        end
        apply(1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 16'h4444);
        chk("wait_done_pc", pc_out, 16'h0020); chk("wait_done_instr", instr, 16'h4444);
        tick();
        apply(1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 16'h5555);
        chk("wait_next_pc", pc_out, 16'h0022);
        tick();

        apply(1'b0, 1'b0, 1'b1, 16'h0030, 1'b1, 16'h0);
        tick();
        apply(1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 16'hF000);
        chk("halt_flag", 16'(halt), 16'h1); chk("halt_instr", instr, 16'hF000);
        chk("halt_wen", 16'(ifid_wen), 16'h1);
        tick();
        for (int i = 0; i < 2; i++) begin
            apply(1'b0, 1'b0, 1'b1, 16'h0100, 1'b1, 16'h1234);
            chk("halted_req", 16'(imem_req), 16'h0); chk("halted_pc", pc_out, 16'h0030);
            chk("halted_wen", 16'(ifid_wen), 16'h0); chk("halted_halt", 16'(halt), 16'h1);
            chk("halted_instr", instr, 16'h0000);
            tick();
        end
        apply(1'b1, 1'b0, 1'b0, 16'h0, 1'b1, 16'h0);
        chk("halted_rst_req", 16'(imem_req), 16'h0);
        tick();
        apply(1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 16'h1234);
        chk("post_halt_pc", pc_out, 16'h0000); chk("post_halt_req", 16'(imem_req), 16'h1);
        tick();

        apply(1'b0, 1'b0, 1'b1, 16'h0030, 1'b1, 16'h0);
        tick();
        apply(1'b0, 1'b0, 1'b1, 16'h0050, 1'b1, 16'hF000);
        chk("squash_halt", 16'(halt), 16'h0); chk("squash_instr", instr, 16'h0000);
        tick();
        apply(1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 16'h1000);
        chk("squash_pc", pc_out, 16'h0050); chk("squash_req", 16'(imem_req), 16'h1);
        tick();

        apply(1'b0, 1'b0, 1'b1, 16'hFFFE, 1'b1, 16'h0);
        tick();
        apply(1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 16'h1000);
        chk("wrap_pc", pc_out, 16'hFFFE); chk("wrap_inc", pc_inc, 16'h0000);
        tick();
        apply(1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 16'h1000);
        chk("wrap_next", pc_out, 16'h0000);
        tick();

        for (int i = 0; i < 2000; i++) begin
            logic [15:0] d;
            d = 16'($urandom);
            if ($urandom_range(0, 9) == 0) d[15:12] = 4'hF;
            else if (d[15:12] == 4'hF) d[15:12] = 4'h3;
            apply(($urandom_range(0, 63) == 0), ($urandom_range(0, 5) == 0),
                  ($urandom_range(0, 7) == 0), 16'($urandom),
                  ($urandom_range(0, 3) != 0), d);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/if_fetch_stage.md
# if_fetch_stage

Instruction-fetch stage of the 16-bit pipelined CPU: owns the PC register, drives the instruction-memory request, computes PC+2, detects HALT and applies branch redirect, stall and memory-wait. Its outputs feed the IF/ID pipeline register directly: pc_out, pc_inc, instr and halt map onto the register's d-side inputs, and ifid_wen drives its write enable. PC-relative branches resolved in ID redirect this stage. A wait state lets the stage run unchanged once the memory becomes multi-cycle.

## Interface
- RESET_PC, 16'h0000, PC value loaded on reset
- NOP_INSTR, 16'h0000, bubble encoding injected on flush or wait
- HALT_OPC, 4'hF, opcode (instr[15:12]) that stops fetch
- clk  in  1  clock, all state updates on posedge
- rst  in  1  reset, synchronous, active-high
- stall  in  1  hazard unit: hold PC and IF/ID
- redirect  in  1  taken branch/jump resolved in ID
- redirect_pc  in  16  branch target
- imem_addr  out  16  fetch address (= PC)
- imem_req  out  1  fetch request
- imem_data  in  16  instruction word, valid when imem_ready=1 in the same cycle
- imem_ready  in  1  memory returns data this cycle
- pc_out  out  16  PC of the presented instruction
- pc_inc  out  16  PC+2
- instr  out  16  presented instruction or NOP_INSTR
- halt  out  1  presented instruction is HALT
- ifid_wen  out  1  IF/ID write enable

## Operation
- States: FETCH, WAIT, HALTED. Registered state: PC[15:0] and the state. All outputs are combinational from PC, state and inputs.
- pc_out = imem_addr = PC. pc_inc = PC + 2, modulo 2^16 (16'hFFFE -> 16'h0000).
- imem_req = 1 in FETCH and WAIT, and 0 in HALTED or while rst=1.
- Priority per cycle: rst > redirect > stall > imem_ready.
- redirect (FETCH or WAIT): PC <= {redirect_pc[15:1],1'b0}, instr = NOP_INSTR, halt = 0, ifid_wen = 1, next state FETCH. Any in-flight fetch is abandoned.
- stall (no redirect): PC and state hold, ifid_wen = 0. imem_req stays asserted.
- FETCH/WAIT, imem_ready = 1, opcode != HALT_OPC: instr = imem_data, ifid_wen = 1, PC <= PC + 2, next state FETCH.
- FETCH/WAIT, imem_ready = 1, opcode == HALT_OPC: instr = imem_data, halt = 1, ifid_wen = 1, PC holds, next state HALTED.
- FETCH/WAIT, imem_ready = 0: instr = NOP_INSTR, halt = 0, ifid_wen = 1 (bubble), PC holds, next state WAIT.
- HALTED: instr = NOP_INSTR, halt = 1, ifid_wen = 0, PC holds. redirect and stall are ignored. Only rst exits this state.

## Timing
- rst = 1 at a posedge sets PC to RESET_PC and state to FETCH. While rst = 1: imem_req = 0, ifid_wen = 0, instr = NOP_INSTR, halt = 0, pc_out = PC.
- Single-cycle fetch with imem_ready tied high: one instruction per cycle, zero added latency. The instruction is captured by IF/ID at the same edge that advances the PC.
- Wait of N cycles inserts N NOP bubbles. The instruction is presented in the cycle imem_ready rises.
- Redirect costs one bubble. The target is fetched in the cycle after redirect.
- Redirect and HALT fetched in the same cycle: redirect wins, HALT is squashed, and the stage does not enter HALTED.
- rst asserted mid-WAIT or in HALTED: the stage is in FETCH at RESET_PC on the next cycle.

## Structure
- Shared CPU package holds: HALT_OPC, NOP_INSTR, the fetch-state enum (FETCH/WAIT/HALTED), and a PC_STEP constant of 2.
- One sub-module, if_pc_reg: a 16-bit PC register with sync reset to RESET_PC, a load enable and a next-PC input. The FSM and next-PC mux stay in if_fetch_stage.

## Test plan
- Reset then imem_ready = 1 with words 0x1234, 0x2345, 0x3456: pc_out is 0x0000, 0x0002, 0x0004, instr follows the words, and ifid_wen = 1 every cycle.
- redirect = 1 with redirect_pc = 0x0041 while fetching 0x0010: that cycle instr = NOP_INSTR. Next cycle pc_out = 0x0040.
- stall high for 2 cycles at PC 0x0008: pc_out stays 0x0008, ifid_wen = 0, and the fetch resumes at 0x0008 with no word skipped.
- imem_ready low for 3 cycles at PC 0x0020: three NOP bubbles with halt = 0, then imem_data is presented at 0x0020, then PC moves to 0x0022.
- Fetch 0xF000 at PC 0x0030: halt = 1, then HALTED with imem_req = 0, PC held, and redirect ignored. rst then returns PC to 0x0000. Repeat with redirect in the same cycle as the HALT fetch: no halt.
- Wrap: with PC = 0xFFFE, pc_inc = 0x0000, and the next fetch is at 0x0000.
